// File: rtl/csr_access_sequencer.sv
// rtl/csr_access_sequencer.sv - Zicsr instruction sequencer: one request in, READ/WRITE cycles to the CSR file, one response out.
module csr_access_sequencer #(
    parameter int MXLEN = 64
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_funct3_i,
    input  logic [11:0]      req_csr_address_i,
    input  logic [MXLEN-1:0] req_rs1_data_i,
    input  logic [4:0]       req_uimm_i,
    input  logic             req_rd_zero_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [MXLEN-1:0] resp_rd_data_o,
    output logic             resp_illegal_o,
    output logic [11:0]      csr_address_o,
    output logic [1:0]       csr_command_o,
    output logic [MXLEN-1:0] csr_write_data_o,
    input  logic [MXLEN-1:0] csr_read_data_i,
    input  logic             csr_read_data_valid_i
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [1:0] CMD_NONE       = 2'b00;
    localparam logic [1:0] CMD_READ_ONLY  = 2'b01;
    localparam logic [1:0] CMD_WRITE_ONLY = 2'b10;

    state_t           state, state_next;
    logic [2:0]       funct3, funct3_next;
    logic [11:0]      address, address_next;
    logic [MXLEN-1:0] src, src_next;
    logic [MXLEN-1:0] old, old_next;
    logic             do_read, do_read_next;
    logic             do_write, do_write_next;
    logic             illegal, illegal_next;

    logic             rw_type;
    logic             read_only;
    logic [MXLEN-1:0] decode_src;

    assign rw_type    = (req_funct3_i[1:0] == 2'b01);
    assign decode_src = req_funct3_i[2] ? {{(MXLEN-5){1'b0}}, req_uimm_i} : req_rs1_data_i;
    assign read_only  = (address[11:10] == 2'b11);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= IDLE;
            funct3   <= '0;
            address  <= '0;
            src      <= '0;
            old      <= '0;
            do_read  <= 1'b0;
            do_write <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state    <= state_next;
            funct3   <= funct3_next;
            address  <= address_next;
            src      <= src_next;
            old      <= old_next;
            do_read  <= do_read_next;
            do_write <= do_write_next;
            illegal  <= illegal_next;
        end
    end

    always_comb begin
        state_next       = state;
        funct3_next      = funct3;
        address_next     = address;
        src_next         = src;
        old_next         = old;
        do_read_next     = do_read;
        do_write_next    = do_write;
        illegal_next     = illegal;
        req_ready_o      = 1'b0;
        csr_command_o    = CMD_NONE;
        csr_write_data_o = '0;

        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    funct3_next   = req_funct3_i;
                    address_next  = req_csr_address_i;
                    src_next      = decode_src;
                    do_read_next  = !(rw_type && req_rd_zero_i);
                    do_write_next = rw_type || (req_uimm_i != 5'd0);
                    old_next      = '0;
                    illegal_next  = (req_funct3_i[1:0] == 2'b00);
                    if (req_funct3_i[1:0] == 2'b00)
                        state_next = RESP;
                    else if (!(rw_type && req_rd_zero_i))
                        state_next = READ;
                    else
                        state_next = WRITE;
                end
            end
            READ: begin
                csr_command_o = CMD_READ_ONLY;
                old_next      = csr_read_data_i;
                if (!csr_read_data_valid_i || (do_write && read_only)) begin
                    illegal_next = 1'b1;
                    old_next     = '0;
                    state_next   = RESP;
                end else if (do_write) begin
                    state_next = WRITE;
                end else begin
                    state_next = RESP;
                end
            end
            WRITE: begin
                state_next = RESP;
                // A write-only access to a read-only CSR never reaches the bus.
                if (!do_read && read_only) begin
                    illegal_next = 1'b1;
                    old_next     = '0;
                end else begin
                    csr_command_o = CMD_WRITE_ONLY;
                    case (funct3[1:0])
                        2'b10:   csr_write_data_o = old | src;
                        2'b11:   csr_write_data_o = old & ~src;
                        default: csr_write_data_o = src;
                    endcase
                    if (!csr_read_data_valid_i) begin
                        illegal_next = 1'b1;
                        old_next     = '0;
                    end
                end
            end
            RESP: begin
                if (resp_ready_i)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign resp_valid_o   = (state == RESP);
    assign resp_rd_data_o = (state == RESP) ? old : '0;
    assign resp_illegal_o = (state == RESP) && illegal;
    assign csr_address_o  = address;

endmodule
